// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main control: opcodes, states, mux selects, ALU ops and the control word.
// MC_CONTROL_BNE_EN adds the bne opcode path and the pcwritecond_ne control bit.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
`ifdef MC_CONTROL_BNE_EN
    logic       pcwritecond_ne;
`endif
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode: registered FSM state to datapath control word.
// FETCH gates irwrite/pcwrite with mem_ready so the IR and PC load only on the completing cycle.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control word; unlisted and unreachable states leave everything low.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_B;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
`ifdef MC_CONTROL_BNE_EN
      S_BNE: begin
        ctrl.alusrca        = 1'b1;
        ctrl.alusrcb        = SRCB_B;
        ctrl.aluop          = ALUOP_SUB;
        ctrl.pcwritecond_ne = 1'b1;
        ctrl.pcsource       = PCSRC_ALUOUT;
      end
`endif
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      default: begin
        ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle main control FSM: state register, opcode-driven next-state logic and reset gating of outputs.
// Define MC_CONTROL_BNE_EN to decode bne (000101) into its own branch state with the pcwritecond_ne port.
module mc_control
  import mc_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
`ifdef MC_CONTROL_BNE_EN
  output logic               pcwritecond_ne,
`endif
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsource,
  output logic               aluop1,
  output logic               aluop0,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  state_t state_q;
  state_t state_d;
  logic   illegal_raw;
  logic   illegal_gated;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl_gated;

  // Next state; unknown opcodes in DECODE return to FETCH and flag illegal.
  always_comb begin
    state_d     = S_FETCH;
    illegal_raw = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  mc_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_dec)
  );

  // Reset aborts any access in flight: all enables, selects and illegal read 0.
  always_comb begin
    if (reset) begin
      ctrl_gated    = CTRL_IDLE;
      illegal_gated = 1'b0;
    end else begin
      ctrl_gated    = ctrl_dec;
      illegal_gated = illegal_raw;
    end
  end

  assign pcwrite        = ctrl_gated.pcwrite;
  assign pcwritecond    = ctrl_gated.pcwritecond;
`ifdef MC_CONTROL_BNE_EN
  assign pcwritecond_ne = ctrl_gated.pcwritecond_ne;
`endif
  assign iord           = ctrl_gated.iord;
  assign memread        = ctrl_gated.memread;
  assign memwrite       = ctrl_gated.memwrite;
  assign irwrite        = ctrl_gated.irwrite;
  assign memtoreg       = ctrl_gated.memtoreg;
  assign regdst         = ctrl_gated.regdst;
  assign regwrite       = ctrl_gated.regwrite;
  assign alusrca        = ctrl_gated.alusrca;
  assign alusrcb        = ctrl_gated.alusrcb;
  assign pcsource       = ctrl_gated.pcsource;
  assign aluop1         = ctrl_gated.aluop[1];
  assign aluop0         = ctrl_gated.aluop[0];
  assign illegal        = illegal_gated;
  assign state_o        = STATE_W'(state_q);

endmodule
